// File: rtl/regfile_wb_ctrl_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_ctrl_if
//
// Bundles every non-clock/reset signal of regfile_wb_ctrl.
//   master : pipeline/hazard side. Drives the ALU and memory writeback
//            requests, wb_hold and query_reg. Observes the readies, the
//            register-file write port, init_busy and query_pending.
//   slave  : the controller itself. Drives the readies, the register-file
//            write port (rf_we / rf_waddr / rf_wdata), init_busy and
//            query_pending.
// ---------------------------------------------------------------------------
interface regfile_wb_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    // ALU writeback request
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;

    // Load writeback request
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;

    // Drain pause
    logic              wb_hold;

    // Register file write port
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    // Status and hazard query
    logic              init_busy;
    logic [ADDR_W-1:0] query_reg;
    logic              query_pending;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        output wb_hold, query_reg,
        input  alu_ready, mem_ready,
        input  rf_we, rf_waddr, rf_wdata,
        input  init_busy, query_pending
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        input  wb_hold, query_reg,
        output alu_ready, mem_ready,
        output rf_we, rf_waddr, rf_wdata,
        output init_busy, query_pending
    );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_wb_ctrl
//
// Owns the register file's single write port.
//   * After reset (INIT) it walks every register 0..NUM_REGS-1 and writes 0,
//     one per cycle, because the register file itself has no reset.
//   * In RUN it merges writeback requests from the ALU and the memory stage
//     into a small in-order FIFO and drains at most one write per cycle.
//   * It answers "is a write to query_reg still pending?" for the hazard unit.
//
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - synchronous active-high reset (returns to INIT, flushes the FIFO)
//   bus  - regfile_wb_ctrl_if.slave:
//            alu_valid/alu_ready/alu_rd/alu_data   ALU writeback request
//            mem_valid/mem_ready/mem_rd/mem_data   load writeback request
//            wb_hold                               pause draining
//            rf_we/rf_waddr/rf_wdata               register-file write port
//            init_busy                             clear sequence running
//            query_reg/query_pending               hazard-unit query
//
// Optional feature (compile-time macro R0_ZERO_EN):
//   When defined, register 0 is hard-wired zero in RUN: queued entries that
//   target register 0 are still dequeued in order but produce rf_we=0 and
//   never raise query_pending. The INIT clear still writes register 0.
//   When undefined, register 0 is an ordinary register.
// ---------------------------------------------------------------------------
module regfile_wb_ctrl #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 4,
    parameter int NUM_REGS   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    regfile_wb_ctrl_if.slave bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Clear index counts one past the last register so the final clear
    // write is still visible on the port while init_busy is high.
    localparam int CLR_W = $clog2(NUM_REGS + 1);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [0:0]        state_reg;
    logic [0:0]        state_next;
    logic [CLR_W-1:0]  clr_idx_reg;
    logic [CLR_W-1:0]  clr_idx_next;

    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_next;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;

    logic              rf_we_reg;
    logic              rf_we_next;
    logic [ADDR_W-1:0] rf_waddr_reg;
    logic [ADDR_W-1:0] rf_waddr_next;
    logic [DATA_W-1:0] rf_wdata_reg;
    logic [DATA_W-1:0] rf_wdata_next;

    // Queue storage; contents need no reset since validity comes from
    // the pointers and count.
    logic [ADDR_W-1:0] fifo_rd   [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];

    // -----------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------
    logic              run;
    logic              mem_ready_c;
    logic              alu_ready_c;
    logic              push_mem;
    logic              push_alu;
    logic              pop;
    logic [PTR_W-1:0]  alu_slot;
    logic [ADDR_W-1:0] head_rd;
    logic [DATA_W-1:0] head_data;
    logic              head_we;

    assign run = (state_reg == ST_RUN);

    // Occupancy is taken at the start of the cycle; a same-cycle pop does not
    // free a slot for a push. Memory has priority on the last free slot.
    assign mem_ready_c = run && (count_reg <= CNT_W'(FIFO_DEPTH - 1));
    assign alu_ready_c = run &&
                         ((count_reg <= CNT_W'(FIFO_DEPTH - 2)) ||
                          ((count_reg == CNT_W'(FIFO_DEPTH - 1)) && !bus.mem_valid));

    assign push_mem = bus.mem_valid && mem_ready_c;
    assign push_alu = bus.alu_valid && alu_ready_c;
    assign pop      = run && (count_reg != '0) && !bus.wb_hold;

    // When both push, the load goes in first and the ALU entry lands behind it.
    assign alu_slot = push_mem ? (wr_ptr_reg + PTR_W'(1)) : wr_ptr_reg;

    assign head_rd   = fifo_rd[rd_ptr_reg];
    assign head_data = fifo_data[rd_ptr_reg];

`ifdef R0_ZERO_EN
    assign head_we = (head_rd != '0);
`else
    assign head_we = 1'b1;
`endif

    // -----------------------------------------------------------------------
    // Queue storage writes
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push_mem) begin
            fifo_rd[wr_ptr_reg]   <= bus.mem_rd;
            fifo_data[wr_ptr_reg] <= bus.mem_data;
        end
        if (push_alu) begin
            fifo_rd[alu_slot]   <= bus.alu_rd;
            fifo_data[alu_slot] <= bus.alu_data;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        clr_idx_next  = clr_idx_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        rf_we_next    = 1'b0;
        rf_waddr_next = rf_waddr_reg;
        rf_wdata_next = rf_wdata_reg;

        case (state_reg)
            ST_INIT: begin
                if (clr_idx_reg == CLR_W'(NUM_REGS)) begin
                    // Last clear write was already issued; leave INIT.
                    state_next = ST_RUN;
                end else begin
                    rf_we_next    = 1'b1;
                    rf_waddr_next = ADDR_W'(clr_idx_reg);
                    rf_wdata_next = '0;
                    clr_idx_next  = clr_idx_reg + CLR_W'(1);
                end
            end

            default: begin
                // Pointer arithmetic wraps naturally (power-of-two depth).
                wr_ptr_next = wr_ptr_reg + PTR_W'(push_mem) + PTR_W'(push_alu);
                rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
                count_next  = count_reg + CNT_W'(push_mem) + CNT_W'(push_alu)
                                        - CNT_W'(pop);
                if (pop) begin
                    rf_we_next    = head_we;
                    rf_waddr_next = head_rd;
                    rf_wdata_next = head_data;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_INIT;
            clr_idx_reg  <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            rf_we_reg    <= 1'b0;
            rf_waddr_reg <= '0;
            rf_wdata_reg <= '0;
        end else begin
            state_reg    <= state_next;
            clr_idx_reg  <= clr_idx_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            rf_we_reg    <= rf_we_next;
            rf_waddr_reg <= rf_waddr_next;
            rf_wdata_reg <= rf_wdata_next;
        end
    end

    // -----------------------------------------------------------------------
    // Pending-write query: any live queue slot or the write currently on the
    // port that targets query_reg.
    // -----------------------------------------------------------------------
    logic [FIFO_DEPTH-1:0] slot_hit;

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
            logic [PTR_W-1:0] slot_off;
            logic             slot_live;
            logic             slot_counts;

            // Distance from the head decides whether the slot holds a live entry.
            assign slot_off  = PTR_W'(gi) - rd_ptr_reg;
            assign slot_live = ({1'b0, slot_off} < count_reg);
`ifdef R0_ZERO_EN
            assign slot_counts = (fifo_rd[gi] != '0);
`else
            assign slot_counts = 1'b1;
`endif
            assign slot_hit[gi] = slot_live && slot_counts &&
                                  (fifo_rd[gi] == bus.query_reg);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.alu_ready     = alu_ready_c;
    assign bus.mem_ready     = mem_ready_c;
    assign bus.rf_we         = rf_we_reg;
    assign bus.rf_waddr      = rf_waddr_reg;
    assign bus.rf_wdata      = rf_wdata_reg;
    assign bus.init_busy     = !run;
    assign bus.query_pending = run &&
                               ((|slot_hit) ||
                                (rf_we_reg && (rf_waddr_reg == bus.query_reg)));

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
module tb_regfile_wb_ctrl;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int NR = 16;
    localparam int D  = 4;

    logic clk;
    logic rst;

    regfile_wb_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    regfile_wb_ctrl #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .FIFO_DEPTH(D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file as seen from outside the controller.
    logic [DW-1:0] tb_rf [NR];
    always @(posedge clk) begin
        if (bus.rf_we === 1'b1) tb_rf[bus.rf_waddr] <= bus.rf_wdata;
    end

    // ---------------- Reference model ----------------
    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] model_rf [NR];
    bit            run;
    bit            exp_we_cur;
    logic [AW-1:0] exp_wa_cur;
    logic [DW-1:0] exp_wd_cur;

    int tests = 0;
    int fails = 0;

    function automatic bit dropped(input logic [AW-1:0] rd);
`ifdef R0_ZERO_EN
        return (rd == '0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
        bus.wb_hold   = 1'b0;
    endtask

    // One RUN cycle: drive, check combinational outputs, clock, check the port.
    task automatic step(input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                        input logic mv, input logic [AW-1:0] mr, input logic [DW-1:0] md,
                        input logic hold, input logic [AW-1:0] qr);
        bit   exp_mr, exp_ar, exp_qp, acc_m, acc_a;
        ent_t e;
        bus.alu_valid = av; bus.alu_rd = ar; bus.alu_data = ad;
        bus.mem_valid = mv; bus.mem_rd = mr; bus.mem_data = md;
        bus.wb_hold   = hold; bus.query_reg = qr;
        #1;
        exp_mr = run && (q.size() < D);
        exp_ar = run && ((q.size() <= D - 2) || (q.size() == D - 1 && !mv));
        exp_qp = 1'b0;
        if (run) begin
            foreach (q[k]) if (q[k].rd == qr && !dropped(q[k].rd)) exp_qp = 1'b1;
            if (exp_we_cur && exp_wa_cur == qr) exp_qp = 1'b1;
        end
        chk("mem_ready", 32'(bus.mem_ready), 32'(exp_mr));
        chk("alu_ready", 32'(bus.alu_ready), 32'(exp_ar));
        chk("query_pending", 32'(bus.query_pending), 32'(exp_qp));
        acc_m = mv && exp_mr;
        acc_a = av && exp_ar;
        exp_we_cur = 1'b0;
        if (run && q.size() > 0 && !hold) begin
            e = q.pop_front();
            exp_we_cur = !dropped(e.rd);
            exp_wa_cur = e.rd;
            exp_wd_cur = e.data;
        end
        if (acc_m) q.push_back('{rd: mr, data: md});
        if (acc_a) q.push_back('{rd: ar, data: ad});
        @(posedge clk); #1;
        chk("rf_we", 32'(bus.rf_we), 32'(exp_we_cur));
        if (exp_we_cur) begin
            chk("rf_waddr", 32'(bus.rf_waddr), 32'(exp_wa_cur));
            chk("rf_wdata", 32'(bus.rf_wdata), 32'(exp_wd_cur));
            model_rf[exp_wa_cur] = exp_wd_cur;
        end
    endtask

    task automatic idle_step(input logic [AW-1:0] qr);
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, qr);
    endtask

    task automatic reset_and_init();
        idle_inputs();
        bus.query_reg = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("rst_rf_waddr", 32'(bus.rf_waddr), 32'd0);
        chk("rst_rf_wdata", 32'(bus.rf_wdata), 32'd0);
        chk("rst_init_busy", 32'(bus.init_busy), 32'd1);
        chk("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
        chk("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
        chk("rst_query_pending", 32'(bus.query_pending), 32'd0);
        rst = 1'b0;
        q.delete();
        run = 1'b0;
        exp_we_cur = 1'b0;
        for (int r = 0; r < NR; r++) model_rf[r] = '0;
        // Requests offered during the clear must all be refused.
        bus.alu_valid = 1'b1; bus.alu_rd = 4'd7; bus.alu_data = 16'h1234;
        bus.mem_valid = 1'b1; bus.mem_rd = 4'd8; bus.mem_data = 16'h5678;
        for (int i = 0; i < NR; i++) begin
            bus.query_reg = AW'(i);
            @(posedge clk); #1;
            chk("init_rf_we", 32'(bus.rf_we), 32'd1);
            chk("init_rf_waddr", 32'(bus.rf_waddr), 32'(i));
            chk("init_rf_wdata", 32'(bus.rf_wdata), 32'd0);
            chk("init_busy", 32'(bus.init_busy), 32'd1);
            chk("init_alu_ready", 32'(bus.alu_ready), 32'd0);
            chk("init_mem_ready", 32'(bus.mem_ready), 32'd0);
            chk("init_query_pending", 32'(bus.query_pending), 32'd0);
        end
        idle_inputs();
        @(posedge clk); #1;
        chk("run_init_busy", 32'(bus.init_busy), 32'd0);
        chk("run_rf_we", 32'(bus.rf_we), 32'd0);
        run = 1'b1;
    endtask

    // Watchdog: the sequence is fixed-length, this only guards against a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        idle_inputs();
        bus.query_reg = '0;
        run = 1'b0;
        exp_we_cur = 1'b0;
        exp_wa_cur = '0;
        exp_wd_cur = '0;

        // Reset clear sequence
        reset_and_init();

        // Single ALU write to r3, watched by the hazard query
        step(1'b1, 4'd3, 16'hBEEF, 1'b0, '0, '0, 1'b0, 4'd3);
        idle_step(4'd3);
        idle_step(4'd3);
        idle_step(4'd3);

        // Same-cycle mem + ALU to r5: mem first, ALU wins
        step(1'b1, 4'd5, 16'h2222, 1'b1, 4'd5, 16'h1111, 1'b0, 4'd5);
        idle_step(4'd5);
        idle_step(4'd5);
        idle_step(4'd5);

        // Fill under hold: ALU-only to three entries, then both sources
        step(1'b1, 4'd1, 16'hA001, 1'b0, '0, '0, 1'b1, 4'd1);
        step(1'b1, 4'd2, 16'hA002, 1'b0, '0, '0, 1'b1, 4'd2);
        step(1'b1, 4'd4, 16'hA004, 1'b0, '0, '0, 1'b1, 4'd4);
        step(1'b1, 4'd6, 16'hA006, 1'b1, 4'd9, 16'hB009, 1'b1, 4'd9);
        step(1'b1, 4'd6, 16'hA006, 1'b1, 4'd10, 16'hB00A, 1'b1, 4'd10);
        step(1'b1, 4'd6, 16'hA006, 1'b1, 4'd10, 16'hB00A, 1'b1, 4'd6);
        for (int i = 0; i < 6; i++) idle_step(AW'(i));

        // Register 0 followed by register 1
        step(1'b1, 4'd0, 16'hC000, 1'b0, '0, '0, 1'b0, 4'd0);
        step(1'b1, 4'd1, 16'hC001, 1'b0, '0, '0, 1'b0, 4'd0);
        idle_step(4'd0);
        idle_step(4'd0);
        idle_step(4'd0);

        // Randomised traffic
        for (int n = 0; n < 300; n++) begin
            step(1'($urandom_range(0, 1)), AW'($urandom_range(0, NR - 1)), DW'($urandom),
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, NR - 1)), DW'($urandom),
                 1'($urandom_range(0, 3) == 0), AW'($urandom_range(0, NR - 1)));
        end
        for (int i = 0; i < D + 2; i++) idle_step(AW'($urandom_range(0, NR - 1)));
        @(posedge clk); #1;
        for (int r = 0; r < NR; r++) chk($sformatf("rf_final_r%0d", r), 32'(tb_rf[r]), 32'(model_rf[r]));

        // Reset in the middle of a held queue
        step(1'b1, 4'd11, 16'hD00B, 1'b1, 4'd12, 16'hD00C, 1'b1, 4'd11);
        step(1'b1, 4'd13, 16'hD00D, 1'b0, '0, '0, 1'b1, 4'd12);
        reset_and_init();
        for (int i = 0; i < D + 2; i++) idle_step(AW'(11 + (i % 3)));
        @(posedge clk); #1;
        for (int r = 0; r < NR; r++) chk($sformatf("rf_after_rst_r%0d", r), 32'(tb_rf[r]), 32'(model_rf[r]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
